// File: rtl/axis_compute_pkg.sv
// Shared types, defaults and helpers for the AXI-Stream compute wrapper.
package axis_compute_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned K_MAX_DEFAULT  = 64;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StClear   = 3'd1,
        StLoadA   = 3'd2,
        StLoadB   = 3'd3,
        StCompute = 3'd4,
        StDrain   = 3'd5,
        StOutput  = 3'd6,
        StDone    = 3'd7
    } state_e;

    // Requested output length forced into 1..k_max.
    function automatic int unsigned clamp_k(input logic [15:0] k, input int unsigned k_max);
        if (k == 16'd0) return 32'd1;
        if (32'(k) > k_max) return k_max;
        return 32'(k);
    endfunction

endpackage

// File: rtl/vec_buffer.sv
// Register-array vector store: one synchronous write port, one combinational read port.
module vec_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Entries are always written before the wrapper reads them, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_compute_wrapper.sv
// Captures vectors A and B from two AXI-Stream slaves, computes C[i] = A[i mod na] * B[i mod nb]
// for K elements, and streams C out; reports completion with done_pulse and a sticky done flag.
module axis_compute_wrapper
    import axis_compute_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned K_MAX  = K_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_axis_a_tdata,
    input  logic              s_axis_a_tvalid,
    output logic              s_axis_a_tready,
    input  logic              s_axis_a_tlast,
    input  logic [DATA_W-1:0] s_axis_b_tdata,
    input  logic              s_axis_b_tvalid,
    output logic              s_axis_b_tready,
    input  logic              s_axis_b_tlast,
    output logic [DATA_W-1:0] m_axis_c_tdata,
    output logic              m_axis_c_tvalid,
    input  logic              m_axis_c_tready,
    output logic              m_axis_c_tlast,
    input  logic [15:0]       cfg_k,
    input  logic              start,
    output logic              done
);

    localparam int unsigned   KW       = $clog2(K_MAX + 1);
    localparam int unsigned   AW       = $clog2(K_MAX);
    localparam logic [KW-1:0] KMaxLast = KW'(K_MAX - 1);

    state_e            state;
    logic              start_q;
    logic              launch;
    logic [KW-1:0]     k_last;   // K - 1
    logic [KW-1:0]     na, nb;   // beats captured into A / B
    logic [KW-1:0]     ia, ib;   // wrapping read pointers for A / B during COMPUTE
    logic [KW-1:0]     ci;       // element being computed
    logic [KW-1:0]     oj;       // element being presented on C
    logic              a_tready_q, b_tready_q, c_tvalid_q, c_tlast_q;
    logic              a_acc, b_acc;
    logic              done_pulse;
    logic              sw_clear_done = 1'b0;
    logic [DATA_W-1:0] a_rd, b_rd, c_rd, c_wr;

    assign launch = (state == StIdle) && start && !start_q;
    assign a_acc  = s_axis_a_tvalid && a_tready_q;
    assign b_acc  = s_axis_b_tvalid && b_tready_q;
    assign c_wr   = a_rd * b_rd;

    assign s_axis_a_tready = a_tready_q;
    assign s_axis_b_tready = b_tready_q;
    assign m_axis_c_tvalid = c_tvalid_q;
    assign m_axis_c_tlast  = c_tlast_q;
    assign m_axis_c_tdata  = c_tvalid_q ? c_rd : '0;

    vec_buffer #(.DATA_W(DATA_W), .DEPTH(K_MAX), .AW(AW)) u_buf_a (
        .clk     (clk),
        .wr_en   (a_acc),
        .wr_addr (na[AW-1:0]),
        .wr_data (s_axis_a_tdata),
        .rd_addr (ia[AW-1:0]),
        .rd_data (a_rd)
    );

    vec_buffer #(.DATA_W(DATA_W), .DEPTH(K_MAX), .AW(AW)) u_buf_b (
        .clk     (clk),
        .wr_en   (b_acc),
        .wr_addr (nb[AW-1:0]),
        .wr_data (s_axis_b_tdata),
        .rd_addr (ib[AW-1:0]),
        .rd_data (b_rd)
    );

    vec_buffer #(.DATA_W(DATA_W), .DEPTH(K_MAX), .AW(AW)) u_buf_c (
        .clk     (clk),
        .wr_en   (state == StCompute),
        .wr_addr (ci[AW-1:0]),
        .wr_data (c_wr),
        .rd_addr (oj[AW-1:0]),
        .rd_data (c_rd)
    );

    // Job sequencer: state, counters and registered stream handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            start_q    <= 1'b0;
            k_last     <= '0;
            na         <= '0;
            nb         <= '0;
            ia         <= '0;
            ib         <= '0;
            ci         <= '0;
            oj         <= '0;
            a_tready_q <= 1'b0;
            b_tready_q <= 1'b0;
            c_tvalid_q <= 1'b0;
            c_tlast_q  <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            start_q    <= start;
            done_pulse <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (launch) begin
                        k_last <= KW'(clamp_k(cfg_k, K_MAX) - 32'd1);
                        state  <= StClear;
                    end
                end
                StClear: begin
                    na         <= '0;
                    nb         <= '0;
                    ia         <= '0;
                    ib         <= '0;
                    ci         <= '0;
                    oj         <= '0;
                    a_tready_q <= 1'b1;
                    state      <= StLoadA;
                end
                StLoadA: begin
                    if (a_acc) begin
                        na <= na + 1'b1;
                        if (s_axis_a_tlast || na == KMaxLast) begin
                            a_tready_q <= 1'b0;
                            b_tready_q <= 1'b1;
                            state      <= StLoadB;
                        end
                    end
                end
                StLoadB: begin
                    if (b_acc) begin
                        nb <= nb + 1'b1;
                        if (s_axis_b_tlast || nb == KMaxLast) begin
                            b_tready_q <= 1'b0;
                            state      <= StCompute;
                        end
                    end
                end
                StCompute: begin
                    // Wrapping pointers replace a modulo on the vector lengths.
                    ia <= (ia + 1'b1 == na) ? '0 : ia + 1'b1;
                    ib <= (ib + 1'b1 == nb) ? '0 : ib + 1'b1;
                    if (ci == k_last) state <= StDrain;
                    else              ci    <= ci + 1'b1;
                end
                StDrain: begin
                    c_tvalid_q <= 1'b1;
                    c_tlast_q  <= (k_last == '0);
                    state      <= StOutput;
                end
                StOutput: begin
                    if (m_axis_c_tready) begin
                        if (oj == k_last) begin
                            c_tvalid_q <= 1'b0;
                            c_tlast_q  <= 1'b0;
                            done_pulse <= 1'b1;
                            state      <= StDone;
                        end else begin
                            oj        <= oj + 1'b1;
                            c_tlast_q <= (oj + 1'b1 == k_last);
                        end
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Sticky completion flag; a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else if (done_pulse) begin
            done <= 1'b1;
        end else if (sw_clear_done || launch) begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_compute_wrapper.sv
// Randomized self-checking bench for axis_compute_wrapper against a queue-based vector model.
module tb_axis_compute_wrapper;

    localparam int K_MAX = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_axis_a_tdata = '0;
    logic        s_axis_a_tvalid = 1'b0;
    logic        s_axis_a_tready;
    logic        s_axis_a_tlast = 1'b0;
    logic [31:0] s_axis_b_tdata = '0;
    logic        s_axis_b_tvalid = 1'b0;
    logic        s_axis_b_tready;
    logic        s_axis_b_tlast = 1'b0;
    logic [31:0] m_axis_c_tdata;
    logic        m_axis_c_tvalid;
    logic        m_axis_c_tready = 1'b0;
    logic        m_axis_c_tlast;
    logic [15:0] cfg_k = '0;
    logic        start = 1'b0;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] a_q[$];
    bit          a_l[$];
    logic [31:0] b_q[$];
    bit          b_l[$];
    logic [31:0] got_d[$];
    bit          got_l[$];

    axis_compute_wrapper dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_a_tdata  (s_axis_a_tdata),
        .s_axis_a_tvalid (s_axis_a_tvalid),
        .s_axis_a_tready (s_axis_a_tready),
        .s_axis_a_tlast  (s_axis_a_tlast),
        .s_axis_b_tdata  (s_axis_b_tdata),
        .s_axis_b_tvalid (s_axis_b_tvalid),
        .s_axis_b_tready (s_axis_b_tready),
        .s_axis_b_tlast  (s_axis_b_tlast),
        .m_axis_c_tdata  (m_axis_c_tdata),
        .m_axis_c_tvalid (m_axis_c_tvalid),
        .m_axis_c_tready (m_axis_c_tready),
        .m_axis_c_tlast  (m_axis_c_tlast),
        .cfg_k           (cfg_k),
        .start           (start),
        .done            (done)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_a_tready"}, s_axis_a_tready, 0);
        check_eq({tag, "_b_tready"}, s_axis_b_tready, 0);
        check_eq({tag, "_c_tvalid"}, m_axis_c_tvalid, 0);
        check_eq({tag, "_c_tlast"}, m_axis_c_tlast, 0);
        check_eq({tag, "_c_tdata"}, m_axis_c_tdata, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_done_pulse"}, dut.done_pulse, 0);
    endtask

    // Rising edge on start; A ready must appear exactly two edges later.
    task automatic launch(input logic [15:0] k);
        @(negedge clk);
        start = 1'b0;
        cfg_k = k;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check_eq("launch_tready_early", s_axis_a_tready, 0);
        check_eq("launch_done_cleared", done, 0);
        @(negedge clk);
        check_eq("launch_tready", s_axis_a_tready, 1);
    endtask

    task automatic send_beat(input bit is_b, input logic [31:0] d, input bit last);
        int t = 0;
        @(negedge clk);
        if (is_b) begin
            s_axis_b_tdata = d; s_axis_b_tlast = last; s_axis_b_tvalid = 1'b1;
        end else begin
            s_axis_a_tdata = d; s_axis_a_tlast = last; s_axis_a_tvalid = 1'b1;
        end
        while (!(is_b ? s_axis_b_tready : s_axis_a_tready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check_eq(is_b ? "b_ready_timeout" : "a_ready_timeout",
                               is_b ? s_axis_b_tready : s_axis_a_tready, 1);
        @(posedge clk);
        #1;
        s_axis_a_tvalid = 1'b0;
        s_axis_b_tvalid = 1'b0;
    endtask

    // Collect k beats with random tready; optionally stall for a fixed span after the first beat.
    task automatic collect(input int k, input int stall);
        int          got = 0;
        int          t = 0;
        int          stall_left = 0;
        bit          held_v = 0;
        logic [31:0] held_d = '0;
        bit          held_l = 0;
        got_d.delete();
        got_l.delete();
        while (got < k && t < 3000) begin
            @(negedge clk);
            t++;
            if (held_v) begin
                check_eq("c_hold_valid", m_axis_c_tvalid, 1);
                check_eq("c_hold_data", m_axis_c_tdata, held_d);
                check_eq("c_hold_last", m_axis_c_tlast, held_l);
            end
            check_eq("done_pulse_early", dut.done_pulse, 0);
            if (stall > 0) check_eq("done_early", done, 0);
            if (stall_left > 0) begin
                m_axis_c_tready = 1'b0;
                stall_left--;
            end else begin
                m_axis_c_tready = 1'($urandom_range(0, 1));
            end
            if (m_axis_c_tvalid && m_axis_c_tready) begin
                got_d.push_back(m_axis_c_tdata);
                got_l.push_back(m_axis_c_tlast);
                got++;
                held_v = 0;
                if (got == 1) stall_left = stall;
            end else if (m_axis_c_tvalid) begin
                held_v = 1;
                held_d = m_axis_c_tdata;
                held_l = m_axis_c_tlast;
            end else begin
                held_v = 0;
            end
        end
    endtask

    // Full job using a_q/a_l and b_q/b_l; expected C computed from the vector rules.
    task automatic run_job(input logic [15:0] cfg, input int stall);
        int          na = 0;
        int          nb = 0;
        int          k;
        logic [31:0] exp_v;
        for (int i = 0; i < a_q.size(); i++) begin
            na++;
            if (a_l[i] || na == K_MAX) break;
        end
        for (int i = 0; i < b_q.size(); i++) begin
            nb++;
            if (b_l[i] || nb == K_MAX) break;
        end
        k = (cfg == 0) ? 1 : (cfg > K_MAX) ? K_MAX : int'(cfg);
        launch(cfg);
        for (int i = 0; i < na; i++) send_beat(0, a_q[i], a_l[i]);
        for (int i = 0; i < nb; i++) send_beat(1, b_q[i], b_l[i]);
        collect(k, stall);
        @(negedge clk);
        m_axis_c_tready = 1'b0;
        check_eq("done_pulse_high", dut.done_pulse, 1);
        check_eq("done_before_pulse", done, 0);
        check_eq("c_valid_after_last", m_axis_c_tvalid, 0);
        @(negedge clk);
        check_eq("done_pulse_width", dut.done_pulse, 0);
        check_eq("done_set", done, 1);
        check_eq("c_count", got_d.size(), k);
        for (int i = 0; i < got_d.size(); i++) begin
            exp_v = a_q[i % na] * b_q[i % nb];
            check_eq($sformatf("c_data[%0d]", i), got_d[i], exp_v);
            check_eq($sformatf("c_last[%0d]", i), got_l[i], (i == k - 1) ? 1 : 0);
        end
    endtask

    task automatic fill_random(input int len_a, input int len_b);
        a_q.delete(); a_l.delete(); b_q.delete(); b_l.delete();
        for (int i = 0; i < len_a; i++) begin
            a_q.push_back($urandom);
            a_l.push_back(i == len_a - 1);
        end
        for (int i = 0; i < len_b; i++) begin
            b_q.push_back($urandom);
            b_l.push_back(i == len_b - 1);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");

        // Single-beat vectors broadcast across K=4.
        a_q = '{32'hA}; a_l = '{1'b1};
        b_q = '{32'hB}; b_l = '{1'b1};
        run_job(16'd4, 0);

        // Sticky done, stray A traffic ignored, start held high never relaunches.
        s_axis_a_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("done_sticky", done, 1);
            check_eq("done_pulse_quiet", dut.done_pulse, 0);
            check_eq("no_relaunch", s_axis_a_tready, 0);
        end
        s_axis_a_tvalid = 1'b0;
        @(negedge clk);
        dut.sw_clear_done = 1'b1;
        @(negedge clk);
        dut.sw_clear_done = 1'b0;
        check_eq("sw_clear", done, 0);
        @(negedge clk);
        check_eq("sw_clear_hold", done, 0);

        // Element-wise product.
        a_q = '{32'd1, 32'd2, 32'd3}; a_l = '{1'b0, 1'b0, 1'b1};
        b_q = '{32'd4, 32'd5, 32'd6}; b_l = '{1'b0, 1'b0, 1'b1};
        run_job(16'd3, 0);

        // K clamps: 0 -> 1, 100 -> K_MAX; A exits on its K_MAX-th beat without tlast.
        fill_random(2, 3);
        run_job(16'd0, 0);
        fill_random(K_MAX, 5);
        for (int i = 0; i < K_MAX; i++) a_l[i] = 1'b0;
        run_job(16'd100, 0);

        // Long backpressure during OUTPUT.
        fill_random(3, 5);
        run_job(16'd8, 20);

        // Random jobs.
        for (int j = 0; j < 4; j++) begin
            fill_random($urandom_range(1, 9), $urandom_range(1, 9));
            run_job(16'($urandom_range(0, 80)), 0);
        end

        // Reset while loading B, then a fresh job.
        launch(16'd5);
        send_beat(0, 32'h1234, 1'b1);
        send_beat(1, 32'h55, 1'b0);
        @(negedge clk);
        check_eq("in_load_b", s_axis_b_tready, 1);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset_idle");
        fill_random(4, 2);
        run_job(16'd6, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
